// File: rtl/cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_bus_arbiter
//
// Shares a single external memory port between the CPU instruction-fetch bus
// (cpui_*) and the data bus (cpud_*). Each requester's one-cycle request pulse
// is latched into a pending slot. Only one memory transaction is outstanding
// at a time. The ack and read data are routed back to the requester that
// issued the transaction. A watchdog closes a transaction the memory never
// acknowledges and raises bus_error for that cycle.
//
// Optional build macro:
//   ARB_RR_EN  - when both requesters are pending at a dispatch, grant the one
//                that lost the previous contended grant. Without it, data
//                always wins over instruction fetch.
//
// Parameters:
//   TIMEOUT    - BUSY cycles without mem_ack before forced completion
//                (0 disables the watchdog)
//
// Ports:
//   clock, reset                 system clock, async active-low reset
//   cpui_request/addr            instruction fetch request pulse and address
//   cpui_rdata/ack               fetch data and completion pulse
//   cpud_request/addr/write      data request pulse, address, direction
//   cpud_byte_enable/wdata       write lanes and write data
//   cpud_rdata/ack               read data and completion pulse
//   mem_request                  memory transaction start pulse
//   mem_addr/write/byte_enable/wdata  transaction fields, held until next dispatch
//   mem_rdata/ack                memory read data and completion
//   bus_error                    pulse alongside a watchdog-forced ack
// ---------------------------------------------------------------------------
module cpu_bus_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpui_request,
    input  logic [31:0] cpui_addr,
    output logic [31:0] cpui_rdata,
    output logic        cpui_ack,
    input  logic        cpud_request,
    input  logic [31:0] cpud_addr,
    input  logic        cpud_write,
    input  logic [3:0]  cpud_byte_enable,
    input  logic [31:0] cpud_wdata,
    output logic [31:0] cpud_rdata,
    output logic        cpud_ack,
    output logic        mem_request,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_error
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    // Width holds the value TIMEOUT so the counter can saturate without wrapping.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'((TIMEOUT > 0) ? TIMEOUT : 0);

    logic [1:0]      r_state;
    logic [WD_W-1:0] r_wd;

    logic            r_pend_i;
    logic [31:0]     r_i_addr;
    logic            r_pend_d;
    logic [31:0]     r_d_addr;
    logic            r_d_write;
    logic [3:0]      r_d_be;
    logic [31:0]     r_d_wdata;

    logic w_busy;
    logic w_wd_fire;
    logic w_done;
    logic w_free;
    logic w_new_i;
    logic w_new_d;
    logic w_want_i;
    logic w_want_d;
    logic w_pick_d;
    logic w_grant_i;
    logic w_grant_d;

    logic [31:0] w_addr_i;
    logic [31:0] w_addr_d;
    logic        w_write_d;
    logic [3:0]  w_be_d;
    logic [31:0] w_wdata_d;

    assign w_busy    = (r_state != ST_IDLE);
    assign w_wd_fire = (TIMEOUT > 0) && w_busy && !mem_ack && (r_wd == WD_LAST);
    assign w_done    = w_busy && (mem_ack || w_wd_fire);
    // The port is free this edge if idle, or the current transaction ends now.
    assign w_free    = !w_busy || w_done;

    // A request from a requester that is already pending or in flight is dropped.
    assign w_new_i   = cpui_request && !r_pend_i && (r_state != ST_BUSY_I);
    assign w_new_d   = cpud_request && !r_pend_d && (r_state != ST_BUSY_D);
    assign w_want_i  = r_pend_i || w_new_i;
    assign w_want_d  = r_pend_d || w_new_d;

    // Bypass: a request arriving on a dispatch edge is issued with its live fields.
    assign w_addr_i  = r_pend_i ? r_i_addr  : cpui_addr;
    assign w_addr_d  = r_pend_d ? r_d_addr  : cpud_addr;
    assign w_write_d = r_pend_d ? r_d_write : cpud_write;
    assign w_be_d    = r_pend_d ? r_d_be    : cpud_byte_enable;
    assign w_wdata_d = r_pend_d ? r_d_wdata : cpud_wdata;

`ifdef ARB_RR_EN
    // 1 = data won the last contended dispatch; resets to instruction.
    logic r_last_d;

    assign w_pick_d = w_want_d && (!w_want_i || !r_last_d);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_d <= 1'b0;
        end else if (w_free && w_want_i && w_want_d) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    assign w_pick_d = w_want_d;
`endif

    assign w_grant_d = w_free && w_pick_d;
    assign w_grant_i = w_free && w_want_i && !w_pick_d;

    // Pending slots and captured request fields
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend_i  <= 1'b0;
            r_i_addr  <= 32'h0;
            r_pend_d  <= 1'b0;
            r_d_addr  <= 32'h0;
            r_d_write <= 1'b0;
            r_d_be    <= 4'h0;
            r_d_wdata <= 32'h0;
        end else begin
            if (w_grant_i) begin
                r_pend_i <= 1'b0;
            end else if (w_new_i) begin
                r_pend_i <= 1'b1;
                r_i_addr <= cpui_addr;
            end
            if (w_grant_d) begin
                r_pend_d <= 1'b0;
            end else if (w_new_d) begin
                r_pend_d  <= 1'b1;
                r_d_addr  <= cpud_addr;
                r_d_write <= cpud_write;
                r_d_be    <= cpud_byte_enable;
                r_d_wdata <= cpud_wdata;
            end
        end
    end

    // Transaction state, memory-side fields and watchdog
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_wd            <= '0;
            mem_request     <= 1'b0;
            mem_addr        <= 32'h0;
            mem_write       <= 1'b0;
            mem_byte_enable <= 4'h0;
            mem_wdata       <= 32'h0;
        end else begin
            mem_request <= w_grant_i || w_grant_d;
            if (w_grant_d) begin
                r_state         <= ST_BUSY_D;
                mem_addr        <= w_addr_d;
                mem_write       <= w_write_d;
                mem_byte_enable <= w_be_d;
                mem_wdata       <= w_wdata_d;
            end else if (w_grant_i) begin
                r_state         <= ST_BUSY_I;
                mem_addr        <= w_addr_i;
                mem_write       <= 1'b0;
                mem_byte_enable <= 4'h0;
                mem_wdata       <= 32'h0;
            end else if (w_done) begin
                r_state <= ST_IDLE;
            end

            if (w_grant_i || w_grant_d) begin
                r_wd <= '0;
            end else if ((TIMEOUT > 0) && w_busy && !mem_ack && (r_wd != WD_MAX)) begin
                r_wd <= r_wd + 1'b1;
            end
        end
    end

    // Requester-side completion; a forced completion returns zero data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpui_ack   <= 1'b0;
            cpui_rdata <= 32'h0;
            cpud_ack   <= 1'b0;
            cpud_rdata <= 32'h0;
            bus_error  <= 1'b0;
        end else begin
            cpui_ack  <= w_done && (r_state == ST_BUSY_I);
            cpud_ack  <= w_done && (r_state == ST_BUSY_D);
            bus_error <= w_wd_fire;
            if (w_done && (r_state == ST_BUSY_I)) begin
                cpui_rdata <= mem_ack ? mem_rdata : 32'h0;
            end
            if (w_done && (r_state == ST_BUSY_D)) begin
                cpud_rdata <= mem_ack ? mem_rdata : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_arbiter
//
// Self-checking bench for cpu_bus_arbiter with TIMEOUT=8. Expected memory
// transactions and expected acks are queued as stimulus is driven and popped
// when the arbiter produces them. A negedge monitor counts ack, bus_error and
// mem_request pulses so tests can detect spurious activity.
// ---------------------------------------------------------------------------
module tb_cpu_bus_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic        w;
        logic [3:0]  be;
        logic [31:0] wd;
    } mem_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rd;
        bit          err;
    } ack_t;

    logic        clock;
    logic        reset;
    logic        cpui_request;
    logic [31:0] cpui_addr;
    logic [31:0] cpui_rdata;
    logic        cpui_ack;
    logic        cpud_request;
    logic [31:0] cpud_addr;
    logic        cpud_write;
    logic [3:0]  cpud_byte_enable;
    logic [31:0] cpud_wdata;
    logic [31:0] cpud_rdata;
    logic        cpud_ack;
    logic        mem_request;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_error;

    mem_t q_mem[$];
    ack_t q_ack[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_iack = 0;
    int n_dack = 0;
    int n_berr = 0;
    int n_mreq = 0;

    cpu_bus_arbiter #(.TIMEOUT(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .cpui_request     (cpui_request),
        .cpui_addr        (cpui_addr),
        .cpui_rdata       (cpui_rdata),
        .cpui_ack         (cpui_ack),
        .cpud_request     (cpud_request),
        .cpud_addr        (cpud_addr),
        .cpud_write       (cpud_write),
        .cpud_byte_enable (cpud_byte_enable),
        .cpud_wdata       (cpud_wdata),
        .cpud_rdata       (cpud_rdata),
        .cpud_ack         (cpud_ack),
        .mem_request      (mem_request),
        .mem_addr         (mem_addr),
        .mem_write        (mem_write),
        .mem_byte_enable  (mem_byte_enable),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack),
        .bus_error        (bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (cpui_ack === 1'b1)    n_iack++;
        if (cpud_ack === 1'b1)    n_dack++;
        if (bus_error === 1'b1)   n_berr++;
        if (mem_request === 1'b1) n_mreq++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        n_cmp++; if (mem_request !== 1'b0) begin n_err++; $display("FAIL reset_mem_request: got %b want 0", mem_request); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_write !== 1'b0 || mem_byte_enable !== 4'h0 || mem_wdata !== 32'h0) begin
            n_err++; $display("FAIL reset_mem_fields: got w=%b be=%h wd=%h want 0", mem_write, mem_byte_enable, mem_wdata); end
        n_cmp++; if (cpui_ack !== 1'b0 || cpud_ack !== 1'b0 || bus_error !== 1'b0) begin
            n_err++; $display("FAIL reset_acks: got i=%b d=%b err=%b want 0", cpui_ack, cpud_ack, bus_error); end
        n_cmp++; if (cpui_rdata !== 32'h0 || cpud_rdata !== 32'h0) begin
            n_err++; $display("FAIL reset_rdata: got i=%h d=%h want 0", cpui_rdata, cpud_rdata); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_ifetch();
        mem_t m;
        ack_t a;
        int di;
        int dd;
        step();
        cpui_request = 1'b1; cpui_addr = 32'h100;
        m = '{32'h100, 1'b0, 4'h0, 32'h0}; q_mem.push_back(m);
        step();
        cpui_request = 1'b0; cpui_addr = 32'h0;
        n_cmp++; if (mem_request !== 1'b1) begin n_err++; $display("FAIL ifetch_latency: mem_request got %b want 1", mem_request); end
        m = q_mem.pop_front();
        n_cmp++; if (mem_addr !== m.addr || mem_write !== m.w || mem_byte_enable !== m.be) begin
            n_err++; $display("FAIL ifetch_fields: got a=%h w=%b be=%h want a=%h w=%b be=%h", mem_addr, mem_write, mem_byte_enable, m.addr, m.w, m.be); end
        di = n_iack; dd = n_dack;
        step();
        n_cmp++; if (mem_request !== 1'b0 || mem_addr !== 32'h100) begin
            n_err++; $display("FAIL ifetch_hold: got req=%b a=%h want req=0 a=00000100", mem_request, mem_addr); end
        step();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        a = '{1'b0, 32'h12345678, 1'b0}; q_ack.push_back(a);
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        a = q_ack.pop_front();
        n_cmp++; if (cpui_ack !== 1'b1 || cpui_rdata !== a.rd || cpud_ack !== 1'b0) begin
            n_err++; $display("FAIL ifetch_ack: got ack=%b rd=%h dack=%b want ack=1 rd=%h dack=0", cpui_ack, cpui_rdata, cpud_ack, a.rd); end
        step();
        n_cmp++; if (cpui_ack !== 1'b0 || cpui_rdata !== 32'h12345678) begin
            n_err++; $display("FAIL ifetch_pulse_hold: got ack=%b rd=%h want ack=0 rd=12345678", cpui_ack, cpui_rdata); end
        n_cmp++; if (n_iack - di != 1 || n_dack != dd) begin
            n_err++; $display("FAIL ifetch_ack_count: got i=%0d d=%0d want i=1 d=0", n_iack - di, n_dack - dd); end
    endtask

    task automatic test_write();
        mem_t m;
        int di;
        int dd;
        cpud_request = 1'b1; cpud_addr = 32'h2000; cpud_write = 1'b1;
        cpud_byte_enable = 4'b0011; cpud_wdata = 32'hCAFEF00D;
        m = '{32'h2000, 1'b1, 4'b0011, 32'hCAFEF00D}; q_mem.push_back(m);
        step();
        cpud_request = 1'b0; cpud_addr = 32'h0; cpud_write = 1'b0; cpud_byte_enable = 4'h0; cpud_wdata = 32'h0;
        n_cmp++; if (mem_request !== 1'b1) begin n_err++; $display("FAIL write_latency: mem_request got %b want 1", mem_request); end
        m = q_mem.pop_front();
        n_cmp++; if (mem_addr !== m.addr || mem_write !== m.w || mem_byte_enable !== m.be || mem_wdata !== m.wd) begin
            n_err++; $display("FAIL write_fields: got a=%h w=%b be=%h wd=%h want a=%h w=%b be=%h wd=%h",
                              mem_addr, mem_write, mem_byte_enable, mem_wdata, m.addr, m.w, m.be, m.wd); end
        di = n_iack; dd = n_dack;
        step();
        n_cmp++; if (mem_wdata !== 32'hCAFEF00D || mem_write !== 1'b1) begin
            n_err++; $display("FAIL write_hold: got w=%b wd=%h want w=1 wd=cafef00d", mem_write, mem_wdata); end
        mem_ack = 1'b1; mem_rdata = 32'h0BADBEEF;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        n_cmp++; if (cpud_ack !== 1'b1 || cpui_ack !== 1'b0) begin
            n_err++; $display("FAIL write_ack: got dack=%b iack=%b want dack=1 iack=0", cpud_ack, cpui_ack); end
        step();
        n_cmp++; if (n_dack - dd != 1 || n_iack != di || cpud_ack !== 1'b0) begin
            n_err++; $display("FAIL write_ack_count: got d=%0d i=%0d now=%b want d=1 i=0 now=0", n_dack - dd, n_iack - di, cpud_ack); end
    endtask

    task automatic test_contention();
        mem_t m;
        ack_t a;
        bit first_d;
        bit kind;
        for (int r = 0; r < 2; r++) begin
            first_d = 1'b1;
`ifdef ARB_RR_EN
            if (r == 1) first_d = 1'b0;
`endif
            if (first_d) begin
                m = '{32'h400 + 32'(r), 1'b0, 4'h0, 32'h0}; q_mem.push_back(m);
                m = '{32'h300 + 32'(r), 1'b0, 4'h0, 32'h0}; q_mem.push_back(m);
            end else begin
                m = '{32'h300 + 32'(r), 1'b0, 4'h0, 32'h0}; q_mem.push_back(m);
                m = '{32'h400 + 32'(r), 1'b0, 4'h0, 32'h0}; q_mem.push_back(m);
            end
            cpui_request = 1'b1; cpui_addr = 32'h300 + 32'(r);
            cpud_request = 1'b1; cpud_addr = 32'h400 + 32'(r); cpud_write = 1'b0; cpud_byte_enable = 4'hF;
            step();
            cpui_request = 1'b0; cpud_request = 1'b0; cpui_addr = 32'h0; cpud_addr = 32'h0; cpud_byte_enable = 4'h0;
            for (int k = 0; k < 2; k++) begin
                kind = (k == 0) ? first_d : !first_d;
                n_cmp++; if (mem_request !== 1'b1) begin
                    n_err++; $display("FAIL contend_issue r%0d k%0d: mem_request got %b want 1", r, k, mem_request); end
                m = q_mem.pop_front();
                n_cmp++; if (mem_addr !== m.addr || mem_write !== 1'b0) begin
                    n_err++; $display("FAIL contend_order r%0d k%0d: got a=%h w=%b want a=%h w=0", r, k, mem_addr, mem_write, m.addr); end
                step();
                mem_ack = 1'b1; mem_rdata = m.addr ^ 32'hA5A5A5A5;
                a = '{kind, m.addr ^ 32'hA5A5A5A5, 1'b0}; q_ack.push_back(a);
                step();
                mem_ack = 1'b0; mem_rdata = 32'h0;
                a = q_ack.pop_front();
                n_cmp++;
                if (a.is_d ? (cpud_ack !== 1'b1 || cpui_ack !== 1'b0 || cpud_rdata !== a.rd)
                           : (cpui_ack !== 1'b1 || cpud_ack !== 1'b0 || cpui_rdata !== a.rd)) begin
                    n_err++; $display("FAIL contend_ack r%0d k%0d: got iack=%b dack=%b ird=%h drd=%h want %s ack rd=%h",
                                      r, k, cpui_ack, cpud_ack, cpui_rdata, cpud_rdata, a.is_d ? "data" : "instr", a.rd); end
            end
            step();
            n_cmp++; if (mem_request !== 1'b0 || cpui_ack !== 1'b0 || cpud_ack !== 1'b0) begin
                n_err++; $display("FAIL contend_quiet r%0d: got req=%b iack=%b dack=%b want 0", r, mem_request, cpui_ack, cpud_ack); end
        end
    endtask

    task automatic test_watchdog();
        mem_t m;
        ack_t a;
        int bad;
        int mr;
        cpud_request = 1'b1; cpud_addr = 32'h500; cpud_write = 1'b0;
        m = '{32'h500, 1'b0, 4'h0, 32'h0}; q_mem.push_back(m);
        step();
        cpud_request = 1'b0; cpud_addr = 32'h0;
        n_cmp++; if (mem_request !== 1'b1) begin n_err++; $display("FAIL wd_issue: mem_request got %b want 1", mem_request); end
        m = q_mem.pop_front();
        n_cmp++; if (mem_addr !== m.addr) begin n_err++; $display("FAIL wd_addr: got %h want %h", mem_addr, m.addr); end
        // Ifetch becomes pending while the data read hangs; a repeat is dropped.
        cpui_request = 1'b1; cpui_addr = 32'h600;
        m = '{32'h600, 1'b0, 4'h0, 32'h0}; q_mem.push_back(m);
        bad = 0;
        step();
        cpui_addr = 32'h700;
        if (cpud_ack !== 1'b0 || bus_error !== 1'b0 || mem_request !== 1'b0) bad++;
        step();
        cpui_request = 1'b0; cpui_addr = 32'h0;
        if (cpud_ack !== 1'b0 || bus_error !== 1'b0 || mem_request !== 1'b0) bad++;
        for (int i = 3; i < 8; i++) begin
            step();
            if (cpud_ack !== 1'b0 || bus_error !== 1'b0 || mem_request !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL wd_early: got %0d active cycles want 0", bad); end
        step();
        n_cmp++; if (cpud_ack !== 1'b1 || cpud_rdata !== 32'h0 || bus_error !== 1'b1 || cpui_ack !== 1'b0) begin
            n_err++; $display("FAIL wd_fire: got dack=%b rd=%h err=%b iack=%b want dack=1 rd=0 err=1 iack=0",
                              cpud_ack, cpud_rdata, bus_error, cpui_ack); end
        m = q_mem.pop_front();
        n_cmp++; if (mem_request !== 1'b1 || mem_addr !== m.addr) begin
            n_err++; $display("FAIL wd_next_dispatch: got req=%b a=%h want req=1 a=%h", mem_request, mem_addr, m.addr); end
        step();
        n_cmp++; if (bus_error !== 1'b0 || cpud_ack !== 1'b0) begin
            n_err++; $display("FAIL wd_pulse: got err=%b dack=%b want 0", bus_error, cpud_ack); end
        mem_ack = 1'b1; mem_rdata = 32'h66666666;
        a = '{1'b0, 32'h66666666, 1'b0}; q_ack.push_back(a);
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        a = q_ack.pop_front();
        n_cmp++; if (cpui_ack !== 1'b1 || cpui_rdata !== a.rd || bus_error !== 1'b0) begin
            n_err++; $display("FAIL wd_ifetch_ack: got ack=%b rd=%h err=%b want ack=1 rd=%h err=0", cpui_ack, cpui_rdata, bus_error, a.rd); end
        mr = n_mreq;
        repeat (6) step();
        n_cmp++; if (n_mreq != mr) begin n_err++; $display("FAIL wd_drop_repeat: got %0d extra mem_request want 0", n_mreq - mr); end
    endtask

    task automatic test_stale_ack();
        ack_t a;
        int di;
        int dd;
        int be;
        di = n_iack; dd = n_dack; be = n_berr;
        mem_ack = 1'b1; mem_rdata = 32'h00000BAD;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) step();
        n_cmp++; if (n_iack != di || n_dack != dd || n_berr != be || cpui_rdata !== 32'h66666666) begin
            n_err++; $display("FAIL stale_ack: got i=%0d d=%0d e=%0d ird=%h want 0 0 0 ird=66666666",
                              n_iack - di, n_dack - dd, n_berr - be, cpui_rdata); end
        cpui_request = 1'b1; cpui_addr = 32'h800;
        step();
        cpui_request = 1'b0; cpui_addr = 32'h0;
        n_cmp++; if (mem_request !== 1'b1 || mem_addr !== 32'h800) begin
            n_err++; $display("FAIL stale_still_idle: got req=%b a=%h want req=1 a=00000800", mem_request, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h88888888;
        a = '{1'b0, 32'h88888888, 1'b0}; q_ack.push_back(a);
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        a = q_ack.pop_front();
        n_cmp++; if (cpui_ack !== 1'b1 || cpui_rdata !== a.rd) begin
            n_err++; $display("FAIL stale_fast_ack: got ack=%b rd=%h want ack=1 rd=%h", cpui_ack, cpui_rdata, a.rd); end
        step();
    endtask

    task automatic test_reset_midop();
        int di;
        int dd;
        int mr;
        cpud_request = 1'b1; cpud_addr = 32'h900; cpud_write = 1'b0;
        step();
        cpud_request = 1'b0; cpud_addr = 32'h0;
        n_cmp++; if (mem_request !== 1'b1 || mem_addr !== 32'h900) begin
            n_err++; $display("FAIL rst_mid_issue: got req=%b a=%h want req=1 a=00000900", mem_request, mem_addr); end
        cpui_request = 1'b1; cpui_addr = 32'hA00;
        step();
        cpui_request = 1'b0; cpui_addr = 32'h0;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (mem_addr !== 32'h0 || mem_request !== 1'b0 || cpui_rdata !== 32'h0 || cpud_rdata !== 32'h0) begin
            n_err++; $display("FAIL rst_mid_async: got a=%h req=%b ird=%h drd=%h want 0", mem_addr, mem_request, cpui_rdata, cpud_rdata); end
        step();
        step();
        reset = 1'b1;
        di = n_iack; dd = n_dack; mr = n_mreq;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (20) step();
        n_cmp++; if (n_iack != di || n_dack != dd || n_mreq != mr) begin
            n_err++; $display("FAIL rst_mid_abandon: got i=%0d d=%0d req=%0d want 0 0 0", n_iack - di, n_dack - dd, n_mreq - mr); end
    endtask

    initial begin
        reset = 1'b0;
        cpui_request = 1'b0; cpui_addr = 32'h0;
        cpud_request = 1'b0; cpud_addr = 32'h0; cpud_write = 1'b0;
        cpud_byte_enable = 4'h0; cpud_wdata = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;

        test_reset();
        test_ifetch();
        test_write();
        test_contention();
        test_watchdog();
        test_stale_ack();
        test_reset_midop();

        n_cmp++; if (q_mem.size() != 0 || q_ack.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got mem=%0d ack=%0d left want 0", q_mem.size(), q_ack.size()); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
